// File: rtl/shared_port_arbiter_if.sv
// rtl/shared_port_arbiter_if.sv - requester/resource bundle for shared_port_arbiter (lock_i exists only with ARB_LOCK_EN)
interface shared_port_arbiter_if;
    logic [3:0] req_i;
    logic       done_i;
`ifdef ARB_LOCK_EN
    logic       lock_i;
`endif
    logic [3:0] grant_o;
    logic [1:0] select_o;
    logic       busy_o;
    logic       timeout_o;

`ifdef ARB_LOCK_EN
    modport slave  (input  req_i, done_i, lock_i,
                    output grant_o, select_o, busy_o, timeout_o);
    modport master (output req_i, done_i, lock_i,
                    input  grant_o, select_o, busy_o, timeout_o);
`else
    modport slave  (input  req_i, done_i,
                    output grant_o, select_o, busy_o, timeout_o);
    modport master (output req_i, done_i,
                    input  grant_o, select_o, busy_o, timeout_o);
`endif
endinterface

// File: rtl/shared_port_arbiter.sv
// rtl/shared_port_arbiter.sv - 4-way round-robin owner arbiter for a shared mux/resource port; ARB_LOCK_EN adds burst lock
module shared_port_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    shared_port_arbiter_if.slave   bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BUSY    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam int               HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       grant_q;
    logic [1:0]       select_q;
    logic             busy_q;

    logic             win_valid;
    logic [1:0]       win_idx;
    logic [1:0]       scan_idx;
    logic             owner_req;
    logic             timeout_hit;
    logic             lock_keep;

    // Winner search: scan from the highest offset down so that the bit
    // closest to the pointer is the last (and therefore winning) assignment.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = ptr;
        scan_idx  = ptr;
        for (int i = 3; i >= 0; i--) begin
            scan_idx = ptr + 2'(i);
            if (bus.req_i[scan_idx]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // select_q holds the owner throughout BUSY, so it indexes the owner's request.
    assign owner_req   = bus.req_i[select_q];
    assign timeout_hit = (MAX_HOLD != 0) && (cnt == HOLD_LAST);

`ifdef ARB_LOCK_EN
    assign lock_keep = bus.lock_i && owner_req;
`else
    assign lock_keep = 1'b0;
`endif

    // Owner FSM: grant on IDLE, hold in BUSY until done/abort/timeout, one idle turnaround cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_IDLE;
            ptr      <= 2'd0;
            cnt      <= '0;
            grant_q  <= 4'b0000;
            select_q <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_valid) begin
                        state    <= ST_BUSY;
                        grant_q  <= 4'b0001 << win_idx;
                        select_q <= win_idx;
                        busy_q   <= 1'b1;
                        cnt      <= '0;
                        ptr      <= win_idx + 2'd1;
                    end
                end
                ST_BUSY: begin
                    if (bus.done_i && lock_keep) begin
                        cnt <= '0;
                    end else if (bus.done_i || !owner_req || timeout_hit) begin
                        state   <= ST_RELEASE;
                        grant_q <= 4'b0000;
                        busy_q  <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    grant_q <= 4'b0000;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Forced-release pulse marks the last BUSY cycle; done and abort both take precedence.
    assign bus.timeout_o = (state == ST_BUSY) && timeout_hit && !bus.done_i && owner_req;

    assign bus.grant_o  = grant_q;
    assign bus.select_o = select_q;
    assign bus.busy_o   = busy_q;

endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb/tb_shared_port_arbiter.sv - table and scoreboard driven bench for shared_port_arbiter (MAX_HOLD=4)
module tb_shared_port_arbiter;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       lock;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       busy;
        logic       to;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    vec_t tbl[$];
    vec_t sb[$];

    shared_port_arbiter_if bus();

    shared_port_arbiter #(.MAX_HOLD(4), .CNT_W(3)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(logic [3:0] req, logic done, logic lock,
                                logic [3:0] grant, logic [1:0] sel, logic busy, logic to);
        vec_t v;
        v.req = req; v.done = done; v.lock = lock;
        v.grant = grant; v.sel = sel; v.busy = busy; v.to = to;
        return v;
    endfunction

    task automatic check(string name, logic [7:0] act, logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, queue its expectation, compare before the next rising edge.
    task automatic step(string tag, vec_t v);
        vec_t e;
        bus.req_i  = v.req;
        bus.done_i = v.done;
`ifdef ARB_LOCK_EN
        bus.lock_i = v.lock;
`endif
        sb.push_back(v);
        #1;
        e = sb.pop_front();
        check({tag, " grant"},   8'(bus.grant_o),   8'(e.grant));
        check({tag, " select"},  8'(bus.select_o),  8'(e.sel));
        check({tag, " busy"},    8'(bus.busy_o),    8'(e.busy));
        check({tag, " timeout"}, 8'(bus.timeout_o), 8'(e.to));
        @(negedge clk_i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] owners [7];
        logic [3:0] greq   [7];
        logic [3:0] zreq   [7];
        owners[0] = 2'd0; owners[1] = 2'd1; owners[2] = 2'd2; owners[3] = 2'd3;
        owners[4] = 2'd0; owners[5] = 2'd1; owners[6] = 2'd0;
        for (int g = 0; g < 7; g++) begin
            greq[g] = (g < 6) ? 4'b1111 : 4'b0011;
            zreq[g] = (g < 5) ? 4'b1111 : ((g == 5) ? 4'b0011 : 4'b0000);
        end

        // Round-robin 0,1,2,3,0 then 1; pointer skip (ptr=2, req=0011 -> 0); then idle.
        tbl.push_back(mk(4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        for (int g = 0; g < 7; g++) begin
            logic [3:0] oh;
            oh = 4'b0001 << owners[g];
            tbl.push_back(mk(greq[g], 1'b0, 1'b0, oh,      owners[g], 1'b1, 1'b0));
            tbl.push_back(mk(greq[g], 1'b1, 1'b0, oh,      owners[g], 1'b1, 1'b0));
            tbl.push_back(mk(zreq[g], 1'b0, 1'b0, 4'b0000, owners[g], 1'b0, 1'b0));
            tbl.push_back(mk(zreq[g], 1'b0, 1'b0, 4'b0000, owners[g], 1'b0, 1'b0));
        end
        tbl.push_back(mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));

        bus.req_i  = 4'b0000;
        bus.done_i = 1'b0;
`ifdef ARB_LOCK_EN
        bus.lock_i = 1'b0;
`endif
        repeat (2) @(negedge clk_i);

        // Requests while reset is held must not produce a grant.
        step("rst_hold0", mk(4'b1111, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        step("rst_hold1", mk(4'b1111, 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        rst_i = 1'b1;

        foreach (tbl[i]) step($sformatf("rr%0d", i), tbl[i]);

        // Timeout: owner 2 held exactly 4 cycles, pulse on the last one.
        step("to_idle", mk(4'b0100, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        for (int c = 0; c < 3; c++)
            step($sformatf("to_busy%0d", c), mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b0));
        step("to_exit", mk(4'b0100, 1'b0, 1'b0, 4'b0100, 2'd2, 1'b1, 1'b1));
        step("to_rel",  mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
        step("to_idle2",mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));

        // Abort on the timeout cycle: owner 3 drops its request, no pulse.
        step("ab_idle", mk(4'b1000, 1'b0, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0));
        for (int c = 0; c < 3; c++)
            step($sformatf("ab_busy%0d", c), mk(4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        step("ab_drop", mk(4'b0000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        step("ab_rel",  mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));
        step("ab_idle2",mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));

        // done coinciding with the timeout cycle wins: no pulse.
        step("co_idle", mk(4'b0001, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));
        for (int c = 0; c < 3; c++)
            step($sformatf("co_busy%0d", c), mk(4'b0001, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        step("co_done", mk(4'b0001, 1'b1, 1'b0, 4'b0001, 2'd0, 1'b1, 1'b0));
        step("co_rel",  mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        step("co_idle2",mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));

        // Asynchronous reset in the middle of BUSY clears outputs immediately.
        step("mr_idle", mk(4'b0010, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));
        bus.req_i = 4'b0010;
        #1;
        check("mr_grant_pre", 8'(bus.grant_o), 8'h02);
        rst_i = 1'b0;
        #1;
        check("mr_grant",   8'(bus.grant_o),   8'h00);
        check("mr_select",  8'(bus.select_o),  8'h00);
        check("mr_busy",    8'(bus.busy_o),    8'h00);
        check("mr_timeout", 8'(bus.timeout_o), 8'h00);
        @(negedge clk_i);
        rst_i = 1'b1;
        step("mr_after", mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0));

`ifdef ARB_LOCK_EN
        // Locked bursts keep owner 3 with no gap; dropping lock releases on the next done.
        step("lk_idle", mk(4'b1000, 1'b0, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0));
        for (int b = 0; b < 3; b++) begin
            step($sformatf("lk_b%0d", b), mk(4'b1000, 1'b0, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0));
            step($sformatf("lk_d%0d", b), mk(4'b1000, 1'b1, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b0));
        end
        step("lk_unlock", mk(4'b1000, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        step("lk_done",   mk(4'b1000, 1'b1, 1'b0, 4'b1000, 2'd3, 1'b1, 1'b0));
        step("lk_rel",    mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));
        step("lk_idle2",  mk(4'b0000, 1'b0, 1'b0, 4'b0000, 2'd3, 1'b0, 1'b0));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
